sha256_core_xr: RTL and testbench
=================================

// Module: sha256_core_xr
// PURPOSE
// - Next-generation SHA-2/256-family compression core for the V2X HSM hash path.
// - Adds a parametrised rounds-per-cycle unroll, runtime SHA-224/SHA-256 mode and a synchronous abort.
// - Processes one 512-bit block per command and chains blocks through init/next.
// - Sits beneath the HSM hash front-end, which handles padding and block buffering.
// PARAMETERS
// - UNROLL  1  compression rounds per clock; legal values 1, 2, 4, 8. Other values fail elaboration.
// PORTS
// - clk           in   1    system clock; all state updates on the rising edge.
// - reset         in   1    asynchronous, active-high reset.
// - init          in   1    start a new message with the IV selected by mode; 1-cycle pulse.
// - next          in   1    chain the next block onto the current H; 1-cycle pulse.
// - abort         in   1    cancel any operation; 1-cycle pulse.
// - mode          in   1    0 = SHA-224, 1 = SHA-256; sampled only when init is accepted.
// - block         in   512  message block, word 0 in [511:480]; sampled only on accept.
// - ready         out  1    core idle and able to accept a command.
// - digest        out  256  SHA-256: H0..H7. SHA-224: {H0..H6, 32'h0}.
// - digest_valid  out  1    digest holds the result of the last completed block.
// BEHAVIOUR
// - Reset values: ready=1, digest_valid=0, H0..H7=0, a..h=0, t_ctr=0, mode_reg=1, FSM=IDLE.
// - FSM states: IDLE, ROUNDS, DONE.
// - Accept: command accepted on an edge only when ready=1 and FSM=IDLE.
// - Priority when several inputs are high together: abort > init > next.
//   - init and next together: act as init.
//   - abort with init or next: act as abort only.
// - Commands while busy: init and next are ignored when ready=0. No queueing, no error.
// - Accept edge actions:
//   - init: load H from the IV selected by mode and latch mode_reg; a..h = that IV.
//   - next: a..h = current H; mode_reg unchanged.
//   - Both: W window = block, t_ctr = 0, digest_valid = 0, ready = 0, FSM goes to ROUNDS.
// - ROUNDS: each edge applies UNROLL chained FIPS 180-4 rounds and adds UNROLL to t_ctr.
//   - The edge with t_ctr == 64 - UNROLL moves the FSM to DONE.
// - DONE: one edge performs Hi += reg_i (mod 2^32) for all 8 words, then ready=1, digest_valid=1, FSM goes to IDLE.
// - Latency: ready and digest_valid rise exactly 64/UNROLL + 1 edges after the accept edge.
//   - UNROLL=1: 65 edges. UNROLL=4: 17 edges.
// - digest_valid stays high until the next accepted init/next, an abort, or reset.
// - digest is the registered H, stable while ready=1; it tracks nothing else.
// - Arithmetic: all additions are 32-bit modulo 2^32. t_ctr is 7 bits and never exceeds 64.
// - Round constants: K index t_ctr + u for u in 0..UNROLL-1.
//   - W words for t >= 16: W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16].
// - abort, any state: on the next edge FSM=IDLE, ready=1, digest_valid=0, t_ctr=0, H0..H7=0. No partial digest is exposed.
// - next after reset or abort with no init: chains from H=0. Deterministic, not a valid hash.
// - Reset asserted mid-operation: immediate return to the reset values; nothing completes.
// - mode and block are don't-care except on accept edges.
// STRUCTURE
// - Package sha2_pkg:
//   - K[0:63] constant array; SHA224_IV and SHA256_IV (8x32 each).
//   - Functions: rotr32, bsig0, bsig1, ssig0, ssig1, ch, maj.
//   - FSM state encoding localparams.
// - Sub-module sha256_w_sched_xr #(UNROLL):
//   - 16x32 sliding window, loaded from block on accept.
//   - Outputs UNROLL consecutive W words per cycle; shifts by UNROLL when advanced.
// - Top level: FSM, t_ctr, a..h, H registers, and the unrolled round chain built with a generate loop.
// TESTING
// - Run every test at UNROLL=1 and UNROLL=4, checking the exact ready latency of 65 and 17 edges.
// - SHA-256 "abc", single padded block, mode=1, init:
//   -> digest ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, digest_valid=1.
// - SHA-224 "abc", mode=0, init:
//   -> digest 23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7_00000000.
// - Two-block "abcdbcdecdef...nopq", init then next:
//   -> intermediate 85e655d6417a17953363376a624cde5c76e09589cac5f811cc4b32c1f20e533a
//   -> final 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
// - Busy-command rejection: init "abc", pulse next with a zero block at cycle 10 and init at cycle 20
//   -> the "abc" digest is unchanged and the latency is unchanged.
// - Abort mid-run: init "abc", abort at round 30
//   -> ready=1 the next edge, digest_valid=0, digest=0; a fresh init "abc" gives the correct digest.
// - Reset mid-run, plus init+abort in the same cycle:
//   -> reset values are restored; the abort wins and no operation starts.

Source files
------------

// File: rtl/sha2_pkg.sv
// Shared SHA-2/256 definitions: round constants, initial hash values,
// FSM state encoding and the bitwise helper functions used by the core.
package sha2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ROUNDS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam int ROUNDS_TOTAL = 64;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Eight 32-bit words, H0 in the most significant word.
  localparam logic [255:0] SHA224_IV = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  localparam logic [255:0] SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr32(x, 2) ^ rotr32(x, 13) ^ rotr32(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr32(x, 6) ^ rotr32(x, 11) ^ rotr32(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr32(x, 7) ^ rotr32(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr32(x, 17) ^ rotr32(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  // One compression round on the packed working state {a,b,c,d,e,f,g,h}.
  function automatic logic [255:0] sha_round(input logic [255:0] s, input logic [31:0] k,
                                             input logic [31:0] w);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + bsig1(e) + ch(e, f, g) + k + w;
    t2 = bsig0(a) + maj(a, b, c);
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  // Word-wise modulo-2^32 sum of two packed 8-word vectors.
  function automatic logic [255:0] add_words(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
    end
    return r;
  endfunction

endpackage

// File: rtl/sha256_w_sched_xr.sv
// Message schedule: a 16-word sliding window over W[t..t+15] that presents
// UNROLL consecutive words per cycle and slides forward by UNROLL on advance.
module sha256_w_sched_xr #(
  parameter int UNROLL = 1
) (
  input  logic                    clk,
  input  logic                    load,
  input  logic                    advance,
  input  logic [511:0]            block,
  output logic [32*UNROLL-1:0]    w_words
);
  import sha2_pkg::*;

  logic [31:0] win [0:15];
  logic [31:0] ext [0:15+UNROLL];

  // Extend the window by UNROLL words; later words may depend on earlier new ones.
  always_comb begin
    // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned and infers a latch.
    for (int i = 0; i < 16 + UNROLL; i++) ext[i] = '0;
    for (int i = 0; i < 16; i++) ext[i] = win[i];
    for (int u = 0; u < UNROLL; u++) begin
      ext[16+u] = ssig1(ext[14+u]) + ext[9+u] + ssig0(ext[1+u]) + ext[u];
    end
  end

  // Present W[t+u] for the round chain, word u in bits [32u +: 32].
  always_comb begin
    w_words = '0;
    for (int u = 0; u < UNROLL; u++) w_words[32*u +: 32] = win[u];
  end

  // Load the block on accept, otherwise slide by UNROLL words while rounds run.
  // NOTE: the window is not reset; it is always loaded from block before any round reads it.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 16; i++) win[i] <= block[511-32*i -: 32];
    end else if (advance) begin
      for (int i = 0; i < 16; i++) win[i] <= ext[i+UNROLL];
    end
  end

endmodule

// File: rtl/sha256_core_xr.sv
// SHA-224/SHA-256 compression core: one 512-bit block per init/next command,
// UNROLL rounds per clock, chaining through the registered H words.
module sha256_core_xr #(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         init,
  input  logic         next,
  input  logic         abort,
  input  logic         mode,
  input  logic [511:0] block,
  output logic         ready,
  output logic [255:0] digest,
  output logic         digest_valid
);
  import sha2_pkg::*;

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8)) begin : g_bad_unroll
    $error("sha256_core_xr: UNROLL must be 1, 2, 4 or 8");
  end

  state_t                state;
  logic [6:0]            t_ctr;
  logic [255:0]          work;
  logic [255:0]          h_reg;
  logic                  mode_reg;
  logic                  accept;
  logic                  advance;
  logic [32*UNROLL-1:0]  w_words;
  logic [255:0]          round_out;

  // abort outranks both commands; init outranks next inside the FSM.
  assign accept  = ready && (state == ST_IDLE) && !abort && (init || next);
  assign advance = (state == ST_ROUNDS) && !abort;

  sha256_w_sched_xr #(.UNROLL(UNROLL)) u_w_sched (
    .clk     (clk),
    .load    (accept),
    .advance (advance),
    .block   (block),
    .w_words (w_words)
  );

  // Chain of UNROLL rounds; stage u uses K[t_ctr+u] and W[t_ctr+u].
  for (genvar u = 0; u < UNROLL; u++) begin : g_round
    logic [255:0] st_in;
    logic [255:0] st_out;
    logic [5:0]   k_idx;
    if (u == 0) begin : g_first
      assign st_in = work;
    end else begin : g_chain
      assign st_in = g_round[u-1].st_out;
    end
    assign k_idx  = t_ctr[5:0] + 6'(u);
    assign st_out = sha_round(st_in, K[k_idx], w_words[32*u +: 32]);
  end
  assign round_out = g_round[UNROLL-1].st_out;

  // SHA-224 exposes only H0..H6; the last word reads as zero.
  assign digest = mode_reg ? h_reg : {h_reg[255:32], 32'h0};

  // Control FSM with registered ready/digest_valid, counter and hash state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      ready        <= 1'b1;
      digest_valid <= 1'b0;
      h_reg        <= '0;
      work         <= '0;
      t_ctr        <= '0;
      mode_reg     <= 1'b1;
    end else if (abort) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      state        <= ST_IDLE;
      ready        <= 1'b1;
      digest_valid <= 1'b0;
      h_reg        <= '0;
      work         <= '0;
      t_ctr        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (init) begin
              h_reg    <= mode ? SHA256_IV : SHA224_IV;
              work     <= mode ? SHA256_IV : SHA224_IV;
              mode_reg <= mode;
            end else begin
              work <= h_reg;
            end
            t_ctr        <= '0;
            digest_valid <= 1'b0;
            ready        <= 1'b0;
            state        <= ST_ROUNDS;
          end
        end
        ST_ROUNDS: begin
          work  <= round_out;
          t_ctr <= t_ctr + 7'(UNROLL);
          if (t_ctr == 7'(ROUNDS_TOTAL - UNROLL)) state <= ST_DONE;
        end
        ST_DONE: begin
          h_reg        <= add_words(h_reg, work);
          ready        <= 1'b1;
          digest_valid <= 1'b1;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_core_xr.sv
// Bench for sha256_core_xr at UNROLL=1 and UNROLL=4 side by side: known-answer
// vectors, random blocks against a plain SHA-256 compression model, busy
// command rejection, abort, next-from-zero and reset behaviour.
module tb_sha256_core_xr;

  logic               clk = 1'b0;
  logic               reset;
  logic [1:0]         init_v, next_v, abort_v, mode_v;
  logic [1:0][511:0]  block_v;
  logic [1:0]         ready_v, dv_v;
  logic [1:0][255:0]  digest_v;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  sha256_core_xr #(.UNROLL(1)) dut1 (
    .clk(clk), .reset(reset), .init(init_v[0]), .next(next_v[0]), .abort(abort_v[0]),
    .mode(mode_v[0]), .block(block_v[0]), .ready(ready_v[0]), .digest(digest_v[0]),
    .digest_valid(dv_v[0])
  );

  sha256_core_xr #(.UNROLL(4)) dut4 (
    .clk(clk), .reset(reset), .init(init_v[1]), .next(next_v[1]), .abort(abort_v[1]),
    .mode(mode_v[1]), .block(block_v[1]), .ready(ready_v[1]), .digest(digest_v[1]),
    .digest_valid(dv_v[1])
  );

  // ---------------- reference model ----------------
  localparam bit [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam bit [255:0] IV224 = 256'hc1059ed8367cd5073070dd17f70e5939ffc00b316858151164f98fa7befa4fa4;
  localparam bit [255:0] IV256 = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  localparam bit [511:0] BLK_ABC = {32'h61626380, 448'h0, 32'h00000018};
  localparam bit [511:0] BLK_TWO1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869,
    32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam bit [511:0] BLK_TWO2 = {480'h0, 32'h000001c0};
  localparam bit [255:0] DG_ABC256 = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam bit [255:0] DG_ABC224 = 256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000;
  localparam bit [255:0] DG_TWO_MID = 256'h85e655d6417a17953363376a624cde5c76e09589cac5f811cc4b32c1f20e533a;
  localparam bit [255:0] DG_TWO_FIN = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  function automatic bit [31:0] rr(input bit [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook compression: full 64-entry schedule then 64 rounds, then feed-forward.
  function automatic bit [255:0] model_compress(input bit [255:0] hin, input bit [511:0] blk);
    bit [31:0] w [64];
    bit [31:0] hv [8];
    bit [31:0] a, b, c, d, e, f, g, h, t1, t2;
    bit [255:0] r;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    for (int i = 0; i < 8; i++) hv[i] = hin[255-32*i -: 32];
    a = hv[0]; b = hv[1]; c = hv[2]; d = hv[3]; e = hv[4]; f = hv[5]; g = hv[6]; h = hv[7];
    for (int t = 0; t < 64; t++) begin
      t1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + w[t];
      t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    r = {hv[0] + a, hv[1] + b, hv[2] + c, hv[3] + d, hv[4] + e, hv[5] + f, hv[6] + g, hv[7] + h};
    return r;
  endfunction

  function automatic bit [255:0] model_digest(input bit m, input bit [255:0] h);
    return m ? h : {h[255:32], 32'h0};
  endfunction

  function automatic bit [511:0] rand_block();
    bit [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    init_v = '0; next_v = '0; abort_v = '0; mode_v = '0; block_v = '0;
  endtask

  // Issue one command, then count edges until ready returns (bounded). Optional
  // pulses (cycle numbers > 0) are injected while the core is busy.
  task automatic run_op(input int d, input bit is_init, input bit m, input bit [511:0] blk,
                        input int next_at, input int init_at, input int abort_at,
                        output int lat, output bit low_after_accept);
    init_v[d] = is_init; next_v[d] = !is_init; mode_v[d] = m; block_v[d] = blk;
    tick();
    init_v[d] = 1'b0; next_v[d] = 1'b0;
    mode_v[d] = 1'($urandom); block_v[d] = rand_block();
    low_after_accept = !ready_v[d];
    lat = -1;
    for (int c = 1; c <= 120; c++) begin
      if (c == next_at) begin next_v[d] = 1'b1; block_v[d] = '0; end
      if (c == init_at) begin init_v[d] = 1'b1; mode_v[d] = !m; end
      if (c == abort_at) abort_v[d] = 1'b1;
      tick();
      init_v[d] = 1'b0; next_v[d] = 1'b0; abort_v[d] = 1'b0;
      if (ready_v[d]) begin
        lat = c;
        break;
      end
    end
  endtask

  function automatic int unroll_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      tests_run++;
      if (ready_v[d] !== 1'b1) begin tests_failed++; $display("FAIL reset_ready U=%0d: got %b expected 1", unroll_of(d), ready_v[d]); end
      tests_run++;
      if (dv_v[d] !== 1'b0) begin tests_failed++; $display("FAIL reset_valid U=%0d: got %b expected 0", unroll_of(d), dv_v[d]); end
      tests_run++;
      if (digest_v[d] !== 256'h0) begin tests_failed++; $display("FAIL reset_digest U=%0d: got %h expected 0", unroll_of(d), digest_v[d]); end
    end
  endtask

  // Run a command and check latency, ready drop and the digest against exp.
  task automatic op_and_check(input int d, input string name, input bit is_init, input bit m,
                              input bit [511:0] blk, input bit [255:0] exp);
    int lat;
    bit low;
    int u = unroll_of(d);
    run_op(d, is_init, m, blk, 0, 0, 0, lat, low);
    tests_run++;
    if (!low) begin tests_failed++; $display("FAIL %s_busy U=%0d: ready still high after accept", name, u); end
    tests_run++;
    if (lat !== 64 / u + 1) begin tests_failed++; $display("FAIL %s_latency U=%0d: got %0d expected %0d", name, u, lat, 64 / u + 1); end
    tests_run++;
    if (dv_v[d] !== 1'b1) begin tests_failed++; $display("FAIL %s_valid U=%0d: got %b expected 1", name, u, dv_v[d]); end
    tests_run++;
    if (digest_v[d] !== exp) begin tests_failed++; $display("FAIL %s_digest U=%0d: got %h expected %h", name, u, digest_v[d], exp); end
  endtask

  task automatic test_known_answers(input int d);
    op_and_check(d, "abc256", 1'b1, 1'b1, BLK_ABC, DG_ABC256);
    op_and_check(d, "abc224", 1'b1, 1'b0, BLK_ABC, DG_ABC224);
    op_and_check(d, "two_mid", 1'b1, 1'b1, BLK_TWO1, DG_TWO_MID);
    op_and_check(d, "two_fin", 1'b0, 1'b1, BLK_TWO2, DG_TWO_FIN);
  endtask

  task automatic test_random(input int d);
    bit m;
    bit [511:0] b;
    bit [255:0] h;
    for (int it = 0; it < 3; it++) begin
      m = 1'($urandom);
      b = rand_block();
      h = model_compress(m ? IV256 : IV224, b);
      op_and_check(d, "rand_init", 1'b1, m, b, model_digest(m, h));
      b = rand_block();
      h = model_compress(h, b);
      // mode on a next is don't-care: drive the opposite value.
      op_and_check(d, "rand_next", 1'b0, !m, b, model_digest(m, h));
    end
  endtask

  task automatic test_busy_reject(input int d);
    int lat;
    bit low;
    int u = unroll_of(d);
    run_op(d, 1'b1, 1'b1, BLK_ABC, 10 / u, 20 / u, 0, lat, low);
    tests_run++;
    if (lat !== 64 / u + 1) begin tests_failed++; $display("FAIL busy_latency U=%0d: got %0d expected %0d", u, lat, 64 / u + 1); end
    tests_run++;
    if (digest_v[d] !== DG_ABC256) begin tests_failed++; $display("FAIL busy_digest U=%0d: got %h expected %h", u, digest_v[d], DG_ABC256); end
    // The rejected commands must not start anything after completion either.
    repeat (3) tick();
    tests_run++;
    if (ready_v[d] !== 1'b1 || dv_v[d] !== 1'b1) begin tests_failed++; $display("FAIL busy_idle U=%0d: got ready=%b valid=%b expected 1 1", u, ready_v[d], dv_v[d]); end
  endtask

  task automatic test_abort(input int d);
    int lat;
    bit low;
    int u = unroll_of(d);
    run_op(d, 1'b1, 1'b1, BLK_ABC, 0, 0, 30 / u, lat, low);
    tests_run++;
    if (lat !== 30 / u) begin tests_failed++; $display("FAIL abort_ready U=%0d: got %0d expected %0d", u, lat, 30 / u); end
    tests_run++;
    if (dv_v[d] !== 1'b0) begin tests_failed++; $display("FAIL abort_valid U=%0d: got %b expected 0", u, dv_v[d]); end
    tests_run++;
    if (digest_v[d] !== 256'h0) begin tests_failed++; $display("FAIL abort_digest U=%0d: got %h expected 0", u, digest_v[d]); end
    op_and_check(d, "after_abort", 1'b1, 1'b1, BLK_ABC, DG_ABC256);
  endtask

  task automatic test_next_from_zero(input int d);
    bit [511:0] b;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    b = rand_block();
    // After reset H=0 and the output format is the full SHA-256 width.
    op_and_check(d, "next_zero", 1'b0, 1'b0, b, model_compress(256'h0, b));
  endtask

  task automatic test_reset_and_abort_win(input int d);
    int u = unroll_of(d);
    init_v[d] = 1'b1; mode_v[d] = 1'b1; block_v[d] = BLK_ABC;
    tick();
    init_v[d] = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    #1;
    tests_run++;
    if (ready_v[d] !== 1'b1 || dv_v[d] !== 1'b0 || digest_v[d] !== 256'h0) begin
      tests_failed++;
      $display("FAIL midrun_reset U=%0d: got ready=%b valid=%b digest=%h expected 1 0 0", u, ready_v[d], dv_v[d], digest_v[d]);
    end
    @(negedge clk); reset = 1'b0;
    tick();
    init_v[d] = 1'b1; abort_v[d] = 1'b1; mode_v[d] = 1'b1; block_v[d] = BLK_ABC;
    tick();
    init_v[d] = 1'b0; abort_v[d] = 1'b0;
    tests_run++;
    if (ready_v[d] !== 1'b1) begin tests_failed++; $display("FAIL init_abort_ready U=%0d: got %b expected 1", u, ready_v[d]); end
    repeat (70) tick();
    tests_run++;
    if (ready_v[d] !== 1'b1 || dv_v[d] !== 1'b0 || digest_v[d] !== 256'h0) begin
      tests_failed++;
      $display("FAIL init_abort_idle U=%0d: got ready=%b valid=%b digest=%h expected 1 0 0", u, ready_v[d], dv_v[d], digest_v[d]);
    end
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk); reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      test_known_answers(d);
      test_random(d);
      test_busy_reject(d);
      test_abort(d);
      test_next_from_zero(d);
      test_reset_and_abort_win(d);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
